irq_pending_ctrl: RTL
=====================

Name: irq_pending_ctrl

Overview:
- Upstream request-collection stage for the 8-to-3 lowest-index-first priority encoder (`priority_encoder8to3`).
- Captures 8 request lines into a sticky pending register and applies a mask.
- Drives the masked pending vector into the encoder.
- Offers the winning 3-bit index to a consumer over a valid/ready handshake, and clears the serviced bit on acceptance.

Parameters:
- EDGE, 1: 1 = rising-edge capture of req_in; 0 = level capture (any high bit sets pending every cycle).

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- req_in  input  8  request lines, bit i = source i
- mask_in  input  8  1 = source i not eligible (its pending bit is retained, not offered)
- out_valid  output  1  an index is being offered
- out_idx  output  3  offered source index, lowest eligible index wins
- out_ready  input  1  consumer accepts out_idx this cycle
- pending  output  8  current pending register
- pend_cnt  output  4  population count of pending, 0..8
- ovf  output  1  sticky: a capture hit a bit that was already pending
- ovf_clr  input  1  synchronous clear of ovf

Behaviour:
- Reset (async, rst=1): pending=0, req_q=0, state=IDLE, out_valid=0, out_idx=0, ovf=0, pend_cnt=0.
- Capture vector:
  - EDGE=1: cap = req_in & ~req_q; req_q <= req_in every cycle.
  - EDGE=0: cap = req_in.
- Pending update each edge: pending <= (pending & ~clr) | cap.
  - clr is the one-hot of out_idx when (out_valid & out_ready), otherwise 0.
  - Set wins over clear on the same bit in the same cycle, so the new event is retained.
- Overflow:
  - ovf <= 1 if any (cap & pending & ~clr) is nonzero.
  - ovf_clr clears ovf; a set in the same cycle wins.
- Eligibility:
  - elig = pending & ~mask_in, fed to the priority_encoder8to3 instance.
  - any = |elig, needed because the encoder outputs 0 both for "none" and for bit 0.
- FSM, 2 states:
  - IDLE: out_valid=0. If any=1, latch out_idx <= encoder output and go to OFFER.
  - OFFER: out_valid=1, out_idx held stable. If out_ready=1, clear pending[out_idx] and go to IDLE; otherwise stay in OFFER.
- No retraction: once in OFFER, later changes to mask_in or new lower-index requests do not alter out_idx until acceptance.
- Throughput: at most one grant per 2 cycles. The IDLE cycle after an acceptance re-evaluates elig.
- Latency:
  - A rising req_in[i] sampled at edge k sets pending[i] at edge k.
  - If the block is idle and elig has no lower bit, out_valid=1 with out_idx=i after edge k+1.
- pend_cnt: combinational popcount of the registered pending vector.
- All bits masked: FSM stays in IDLE, pending is retained, ovf can still set.
- Reset asserted during OFFER: outputs go to reset values immediately; the in-flight offer is discarded.

Decomposition:
- Shared package holds:
  - NSRC=8, IDXW=3, CNTW=4
  - state enum {IDLE, OFFER}
- Sub-module: one instance of the existing priority_encoder8to3, driven by elig; its output is used only when any=1.
- Popcount and FSM stay inline.

Test Plan:
- Reset then a single request: rst pulse; req_in=8'b0010_0000 rising at edge 3; out_ready=1 → out_valid=1, out_idx=5 after edge 4; pending=0 after edge 5; pend_cnt 1→0.
- Priority order:
  - Stimulus: req_in=8'b1001_0100 rising together; out_ready held 1.
  - Response: grants 2, then 4, then 7, on alternate cycles; pending ends at 0.
- Mask and no retraction:
  - Stimulus: pending=8'b0000_0110, mask_in=8'b0000_0010.
  - Response: offers idx 2.
  - Stimulus: assert mask_in=8'b0000_0110 during OFFER with out_ready=0 for 3 cycles.
  - Response: out_idx stays 2. After acceptance, FSM stays in IDLE and pending=8'b0000_0010.
- Overflow:
  - Stimulus: req_in[3] pulses twice while pending[3]=1 and out_ready=0.
  - Response: ovf=1 and pend_cnt=1.
  - Stimulus: ovf_clr=1.
  - Response: ovf=0 next cycle.
- Simultaneous set and clear: req_in[0] rises in the same cycle that idx 0 is accepted → pending[0] stays 1, ovf stays 0, idx 0 is offered again after the IDLE cycle.
- Async reset mid-offer: rst asserted between edges while out_valid=1 → out_valid, pending, and ovf go to 0 without waiting for clk; normal operation resumes after release.

Source files
------------

// File: rtl/irq_pending_ctrl_pkg.sv
// Shared definitions for the interrupt pending/offer stage.
package irq_pending_ctrl_pkg;

  localparam int NSRC = 8;
  localparam int IDXW = 3;
  localparam int CNTW = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  // Number of set bits in a source vector.
  function automatic logic [CNTW-1:0] popcount(input logic [NSRC-1:0] v);
    logic [CNTW-1:0] n;
    n = '0;
    for (int i = 0; i < NSRC; i++) begin
      n = n + {{(CNTW-1){1'b0}}, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/priority_encoder8to3.sv
// Lowest-index-first 8-to-3 priority encoder. Outputs 0 when no bit is set,
// so callers needing "none" must OR-reduce the input themselves.
module priority_encoder8to3
  import irq_pending_ctrl_pkg::*;
(
  input  logic [NSRC-1:0] req,
  output logic [IDXW-1:0] idx
);

  // Scan from the top down so the lowest set bit is the last to write idx.
  always_comb begin
    idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) idx = i[IDXW-1:0];
    end
  end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Collects request lines into a sticky pending register, masks them, and
// offers the lowest eligible index to a consumer. The serviced bit is
// cleared when the consumer accepts.
//
// Handshake: out_valid/out_idx are registered. Once out_valid rises, out_idx
// is held stable until a cycle with out_valid=1 and out_ready=1; that cycle
// is the transfer. The offer is never withdrawn before transfer (except by
// reset). The cycle after a transfer is always idle.
module irq_pending_ctrl
  import irq_pending_ctrl_pkg::*;
#(
  parameter bit EDGE = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] req_in,
  input  logic [NSRC-1:0] mask_in,
  output logic            out_valid,
  output logic [IDXW-1:0] out_idx,
  input  logic            out_ready,
  output logic [NSRC-1:0] pending,
  output logic [CNTW-1:0] pend_cnt,
  output logic            ovf,
  input  logic            ovf_clr
);

  state_t          state;
  logic [NSRC-1:0] req_q;
  logic [NSRC-1:0] cap;
  logic [NSRC-1:0] clr;
  logic [NSRC-1:0] elig;
  logic            any;
  logic [IDXW-1:0] enc_idx;

  assign cap  = EDGE ? (req_in & ~req_q) : req_in;
  assign elig = pending & ~mask_in;
  assign any  = |elig;

  // One-hot clear of the index being transferred this cycle.
  always_comb begin
    clr = '0;
    if (out_valid && out_ready) clr[out_idx] = 1'b1;
  end

  priority_encoder8to3 u_enc (
    .req (elig),
    .idx (enc_idx)
  );

  // Request history, pending bits and sticky overflow. A new capture wins
  // over a clear of the same bit so the fresh event is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q   <= '0;
      pending <= '0;
      ovf     <= 1'b0;
    end else begin
      req_q   <= req_in;
      pending <= (pending & ~clr) | cap;
      if (|(cap & pending & ~clr)) ovf <= 1'b1;
      else if (ovf_clr)            ovf <= 1'b0;
    end
  end

  // Offer FSM: latch the winner in IDLE, hold it in OFFER until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            out_idx   <= enc_idx;
            out_valid <= 1'b1;
            state     <= OFFER;
          end
        end
        OFFER: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign pend_cnt = popcount(pending);

endmodule
